// File: rtl/pcsb_drain_arbiter_pkg.sv
// Shared types for the store-buffer drain / load arbiter in front of the D-cache port.
package pcsb_drain_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/pcsb_drain_arbiter.sv
// Arbitrates post-commit store drains and LSU loads onto one D-cache port,
// one request outstanding; loads win unless the buffer is full or drains starve.
module pcsb_drain_arbiter
    import pcsb_drain_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        drain_valid,
    output logic        drain_ready,
    input  logic [31:0] drain_addr,
    input  logic [3:0]  drain_wmask,
    input  logic [31:0] drain_wdata,
    output logic        drain_resp,
    input  logic        buf_full,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_rmask,
    output logic [31:0] ld_rdata,
    output logic        ld_resp,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t  state_q, state_d;
    dmem_req_t   req_q, req_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0] ld_rdata_q, ld_rdata_d;
    logic        ld_resp_q, ld_resp_d;
    logic        drain_resp_q, drain_resp_d;
    logic        st_grant, ld_grant;

    // Readies are held low while reset is asserted so no fire can be seen during reset.
    always_comb begin
        st_grant = rst_n && (state_q == IDLE) && drain_valid &&
                   (!ld_valid || buf_full || (starve_q == STARVE_LIM));
        ld_grant = rst_n && (state_q == IDLE) && ld_valid && !st_grant;
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        starve_d     = starve_q;
        ld_rdata_d   = ld_rdata_q;
        ld_resp_d    = 1'b0;
        drain_resp_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_grant) begin
                    req_d    = '{addr: word_align(drain_addr), rmask: 4'h0,
                                 wmask: drain_wmask, wdata: drain_wdata};
                    starve_d = '0;
                    if (drain_wmask != 4'h0) state_d = ST_WAIT;
                    else                     drain_resp_d = 1'b1;
                end else if (ld_grant) begin
                    req_d = '{addr: word_align(ld_addr), rmask: ld_rmask,
                              wmask: 4'h0, wdata: 32'h0};
                    if (drain_valid && (starve_q != STARVE_LIM)) starve_d = starve_q + 1'b1;
                    if (ld_rmask != 4'h0) begin
                        state_d = LD_WAIT;
                    end else begin
                        ld_resp_d  = 1'b1;
                        ld_rdata_d = 32'h0;
                    end
                end
            end
            LD_WAIT: begin
                if (dmem_resp) begin
                    state_d     = IDLE;
                    req_d.rmask = 4'h0;
                    ld_rdata_d  = dmem_rdata;
                    ld_resp_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_resp) begin
                    state_d      = IDLE;
                    req_d.wmask  = 4'h0;
                    drain_resp_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            starve_q     <= '0;
            ld_rdata_q   <= 32'h0;
            ld_resp_q    <= 1'b0;
            drain_resp_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_q     <= starve_d;
            ld_rdata_q   <= ld_rdata_d;
            ld_resp_q    <= ld_resp_d;
            drain_resp_q <= drain_resp_d;
        end
    end

    assign drain_ready = st_grant;
    assign ld_ready    = ld_grant;
    assign drain_resp  = drain_resp_q;
    assign ld_resp     = ld_resp_q;
    assign ld_rdata    = ld_rdata_q;
    assign dmem_addr   = req_q.addr;
    assign dmem_rmask  = req_q.rmask;
    assign dmem_wmask  = req_q.wmask;
    assign dmem_wdata  = req_q.wdata;

endmodule

// File: tb/tb_pcsb_drain_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/requests/responses, a monitor pops them.
module tb_pcsb_drain_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drain_valid = 0, buf_full = 0, ld_valid = 0;
    logic [31:0] drain_addr = 0, drain_wdata = 0, ld_addr = 0;
    logic [3:0]  drain_wmask = 0, ld_rmask = 0;
    logic        drain_ready, drain_resp, ld_ready, ld_resp;
    logic [31:0] ld_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;

    logic        model_resp = 0, force_resp = 0, model_en = 1;
    int          dly = 0;
    int          mcnt = 0;
    logic [31:0] rd_val = 0;

    assign dmem_resp  = model_resp | force_resp;
    assign dmem_rdata = rd_val;

    always #5 clk = ~clk;

    pcsb_drain_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_wmask(drain_wmask), .drain_wdata(drain_wdata), .drain_resp(drain_resp),
        .buf_full(buf_full),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
        .ld_rdata(ld_rdata), .ld_resp(ld_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;
    typedef struct {
        bit          is_ld;
        logic [31:0] rdata;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    bit   exp_gnt[$];   // 1 = store grant, 0 = load grant
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got an event, expected none", nm);
    endtask

    // D-cache model: responds dly cycles after a request first appears.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_resp = 1'b0;
            mcnt = 0;
        end else if (model_resp) begin
            model_resp = 1'b0;
        end else if (model_en && ((dmem_rmask | dmem_wmask) != 4'h0)) begin
            if (mcnt >= dly) begin
                model_resp = 1'b1;
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end
    end

    logic [3:0] prev_m = 4'h0;
    always @(negedge clk) begin
        bit   g;
        req_t q;
        rsp_t r;
        if (rst_n) begin
            if (drain_ready && ld_ready) unexp("both_ready");
            if (drain_valid && drain_ready) begin
                if (exp_gnt.size() == 0) unexp("store_grant");
                else begin g = exp_gnt.pop_front(); chk("grant_kind", 32'h1, 32'(g)); end
            end
            if (ld_valid && ld_ready) begin
                if (exp_gnt.size() == 0) unexp("load_grant");
                else begin g = exp_gnt.pop_front(); chk("grant_kind", 32'h0, 32'(g)); end
            end
            if (((dmem_rmask | dmem_wmask) != 4'h0) && (prev_m == 4'h0)) begin
                if (exp_req.size() == 0) unexp("dmem_request");
                else begin
                    q = exp_req.pop_front();
                    chk("dmem_addr", dmem_addr, q.addr);
                    chk("dmem_rmask", 32'(dmem_rmask), 32'(q.rmask));
                    chk("dmem_wmask", 32'(dmem_wmask), 32'(q.wmask));
                    if (q.wmask != 4'h0) chk("dmem_wdata", dmem_wdata, q.wdata);
                end
            end
            if (drain_resp) begin
                if (exp_rsp.size() == 0) unexp("drain_resp");
                else begin r = exp_rsp.pop_front(); chk("resp_kind_drain", 32'h0, 32'(r.is_ld)); end
            end
            if (ld_resp) begin
                if (exp_rsp.size() == 0) unexp("ld_resp");
                else begin
                    r = exp_rsp.pop_front();
                    chk("resp_kind_ld", 32'h1, 32'(r.is_ld));
                    chk("ld_rdata", ld_rdata, r.rdata);
                end
            end
        end
        prev_m = dmem_rmask | dmem_wmask;
    end

    task automatic exp_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        exp_gnt.push_back(1'b1);
        if (m != 4'h0) exp_req.push_back('{addr: a, rmask: 4'h0, wmask: m, wdata: d});
        exp_rsp.push_back('{is_ld: 1'b0, rdata: 32'h0});
    endtask

    task automatic exp_ld(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        exp_gnt.push_back(1'b0);
        if (m != 4'h0) exp_req.push_back('{addr: a, rmask: m, wmask: 4'h0, wdata: 32'h0});
        exp_rsp.push_back('{is_ld: 1'b1, rdata: d});
    endtask

    // Returns just after the clock edge on which the n-th fire is taken.
    task automatic run_grants(input int n);
        int c = 0;
        int b = 0;
        while (c < n && b < 200) begin
            @(negedge clk);
            b++;
            if ((drain_valid && drain_ready) || (ld_valid && ld_ready)) c++;
        end
        if (c < n) unexp("grant_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int b = 0;
        while ((exp_rsp.size() != 0 || exp_req.size() != 0 || exp_gnt.size() != 0) && b < 200) begin
            @(negedge clk);
            b++;
        end
        tests++;
        if (exp_rsp.size() != 0 || exp_req.size() != 0 || exp_gnt.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0",
                     exp_gnt.size(), exp_req.size(), exp_rsp.size());
            exp_rsp.delete(); exp_req.delete(); exp_gnt.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: outputs all zero even with requests pending at the inputs.
        drain_valid = 1; ld_valid = 1; drain_wmask = 4'hF; ld_rmask = 4'hF;
        #12;
        chk("rst_drain_ready", 32'(drain_ready), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_drain_resp", 32'(drain_resp), 32'h0);
        chk("rst_ld_resp", 32'(ld_resp), 32'h0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_rmask", 32'(dmem_rmask), 32'h0);
        chk("rst_dmem_wmask", 32'(dmem_wmask), 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        drain_valid = 0; ld_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Lone drain, then lone load.
        dly = 2;
        exp_st(32'h1000_0004, 4'b1100, 32'hAABB_0000);
        drain_addr = 32'h1000_0006; drain_wmask = 4'b1100; drain_wdata = 32'hAABB_0000;
        drain_valid = 1;
        run_grants(1);
        drain_valid = 0;
        wait_done();
        rd_val = 32'hAABB_1234;
        exp_ld(32'h1000_0004, 4'hF, 32'hAABB_1234);
        ld_addr = 32'h1000_0004; ld_rmask = 4'hF; ld_valid = 1;
        run_grants(1);
        ld_valid = 0;
        wait_done();

        // Contention: L,L,L,L,S twice.
        dly = 0;
        rd_val = 32'h1111_2222;
        drain_addr = 32'h2000_0008; drain_wmask = 4'hF; drain_wdata = 32'h5555_AAAA;
        ld_addr = 32'h3000_000C; ld_rmask = 4'h3;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) exp_ld(32'h3000_000C, 4'h3, 32'h1111_2222);
            exp_st(32'h2000_0008, 4'hF, 32'h5555_AAAA);
        end
        drain_valid = 1; ld_valid = 1;
        run_grants(10);
        chk("starve_after_store", 32'(dut.starve_q), 32'h0);
        drain_valid = 0; ld_valid = 0;
        wait_done();

        // buf_full forces a store ahead of a waiting load.
        exp_ld(32'h3000_000C, 4'h3, 32'h1111_2222);
        exp_ld(32'h3000_000C, 4'h3, 32'h1111_2222);
        drain_valid = 1; ld_valid = 1;
        run_grants(2);
        chk("starve_two_loads", 32'(dut.starve_q), 32'h2);
        exp_st(32'h2000_0008, 4'hF, 32'h5555_AAAA);
        buf_full = 1;
        run_grants(1);
        chk("starve_after_full", 32'(dut.starve_q), 32'h0);
        exp_ld(32'h3000_000C, 4'h3, 32'h1111_2222);
        drain_valid = 0;
        run_grants(1);
        ld_valid = 0; buf_full = 0;
        wait_done();

        // Zero-mask drain and zero-mask load complete without a D-cache request.
        exp_st(32'h4000_0000, 4'h0, 32'hDEAD_BEEF);
        drain_addr = 32'h4000_0001; drain_wmask = 4'h0; drain_wdata = 32'hDEAD_BEEF;
        drain_valid = 1;
        run_grants(1);
        drain_valid = 0;
        @(negedge clk);
        chk("zero_drain_resp", 32'(drain_resp), 32'h1);
        chk("zero_drain_wmask", 32'(dmem_wmask), 32'h0);
        wait_done();
        exp_ld(32'h4000_0000, 4'h0, 32'h0);
        ld_addr = 32'h4000_0000; ld_rmask = 4'h0; ld_valid = 1;
        run_grants(1);
        ld_valid = 0;
        @(negedge clk);
        chk("zero_ld_resp", 32'(ld_resp), 32'h1);
        chk("zero_ld_rmask", 32'(dmem_rmask), 32'h0);
        wait_done();

        // Reset during ST_WAIT abandons the write.
        model_en = 0;
        exp_gnt.push_back(1'b1);
        exp_req.push_back('{addr: 32'h5000_0000, rmask: 4'h0, wmask: 4'hF, wdata: 32'hCAFE_F00D});
        drain_addr = 32'h5000_0002; drain_wmask = 4'hF; drain_wdata = 32'hCAFE_F00D;
        drain_valid = 1;
        run_grants(1);
        drain_valid = 0;
        @(negedge clk);
        chk("st_wait_wmask", 32'(dmem_wmask), 32'hF);
        #2 rst_n = 0;
        #1;
        chk("async_rst_wmask", 32'(dmem_wmask), 32'h0);
        chk("async_rst_addr", dmem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        force_resp = 1;
        @(posedge clk); #1;
        force_resp = 0;
        repeat (3) @(posedge clk); #1;
        model_en = 1;
        dly = 1;
        exp_st(32'h6000_0004, 4'b0011, 32'h1234_5678);
        drain_addr = 32'h6000_0007; drain_wmask = 4'b0011; drain_wdata = 32'h1234_5678;
        drain_valid = 1;
        run_grants(1);
        drain_valid = 0;
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
